// File: rtl/spi_master_if.sv
// spi_master_if: host control and SPI pin bundle for spi_master.
// Handshake: go is sampled on a rising clk edge while the master is idle
// and done is low; busy rises the next cycle and stays high for the whole
// transfer; done pulses high for exactly one cycle, in the same cycle busy
// falls and datao takes the received word. go while busy or done is ignored.
interface spi_master_if #(
   parameter int DATA_WIDTH        = 8,
   parameter int CLK_DIVIDER_WIDTH = 4
);
   logic                         CPOL;
   logic                         CPHA;
   logic [CLK_DIVIDER_WIDTH-1:0] clk_divider;
   logic                         go;
   logic [DATA_WIDTH-1:0]        datai;
   logic [DATA_WIDTH-1:0]        datao;
   logic                         busy;
   logic                         done;
   logic                         sclk;
   logic                         csb;
   logic                         din;
   logic                         dout;

   modport master (
      input  CPOL, CPHA, clk_divider, go, datai, dout,
      output datao, busy, done, sclk, csb, din
   );

   modport slave (
      output CPOL, CPHA, clk_divider, go, datai, dout,
      input  datao, busy, done, sclk, csb, din
   );
endinterface

// File: rtl/spi_master.sv
// spi_master: single-channel full-duplex SPI master, all four CPOL/CPHA modes,
// SCLK half-period of clk_divider+1 system clocks.
// Optional macro SPI_LSB_FIRST_EN: shift LSB first instead of MSB first.
module spi_master #(
   parameter int DATA_WIDTH        = 8,
   parameter int CLK_DIVIDER_WIDTH = 4
) (
   input  logic         clk,
   input  logic         resetb,
   spi_master_if.master bus,
   output logic [1:0]   state_dbg
);

   localparam int EW = $clog2(2 * DATA_WIDTH);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TRAIL = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [CLK_DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
   logic [CLK_DIVIDER_WIDTH-1:0] div_q, div_d;
   logic                         cpol_q, cpol_d;
   logic                         cpha_q, cpha_d;
   logic                         phase_q, phase_d;
   logic [EW-1:0]                edge_q, edge_d;
   logic [DATA_WIDTH-1:0]        tx_q, tx_d;
   logic [DATA_WIDTH-1:0]        rx_q, rx_d;
   logic [DATA_WIDTH-1:0]        datao_q, datao_d;
   logic                         din_q, din_d;
   logic                         busy_q, busy_d;
   logic                         csb_q, csb_d;
   logic                         done_q, done_d;

   // Bit-order dependent views of the shift registers.
   logic                  tx_bit;
   logic [DATA_WIDTH-1:0] tx_rest;
   logic                  load_bit;
   logic [DATA_WIDTH-1:0] load_rest;
   logic [DATA_WIDTH-1:0] rx_next;

   logic tick;
   logic leading;
   logic last_edge;

`ifdef SPI_LSB_FIRST_EN
   assign tx_bit    = tx_q[0];
   assign tx_rest   = tx_q >> 1;
   assign load_bit  = bus.datai[0];
   assign load_rest = bus.datai >> 1;
   assign rx_next   = {bus.dout, rx_q[DATA_WIDTH-1:1]};
`else
   assign tx_bit    = tx_q[DATA_WIDTH-1];
   assign tx_rest   = tx_q << 1;
   assign load_bit  = bus.datai[DATA_WIDTH-1];
   assign load_rest = bus.datai << 1;
   assign rx_next   = {rx_q[DATA_WIDTH-2:0], bus.dout};
`endif

   // Half-period timer expiry and SCLK edge classification (edge k = edge_q+1).
   assign tick      = (cnt_q == div_q);
   assign leading   = ~edge_q[0];
   assign last_edge = (edge_q == LAST_EDGE);

   // State register and datapath flops with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         phase_q <= 1'b0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         datao_q <= '0;
         din_q   <= 1'b0;
         busy_q  <= 1'b0;
         csb_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         phase_q <= phase_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         datao_q <= datao_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         csb_q   <= csb_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath logic: accept, half-period timing, SCLK edges, finish.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      phase_d = phase_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      datao_d = datao_q;
      din_d   = din_q;
      busy_d  = busy_q;
      csb_d   = csb_q;
      done_d  = 1'b0;

      if (state_q != ST_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // A go coinciding with the done pulse is deliberately dropped.
            if (bus.go && !done_q) begin
               state_d = ST_LEAD;
               busy_d  = 1'b1;
               csb_d   = 1'b0;
               cnt_d   = '0;
               div_d   = bus.clk_divider;
               cpol_d  = bus.CPOL;
               cpha_d  = bus.CPHA;
               phase_d = 1'b0;
               edge_d  = '0;
               rx_d    = '0;
               if (!bus.CPHA) begin
                  // Mode with leading-edge sampling needs the first bit up front.
                  din_d = load_bit;
                  tx_d  = load_rest;
               end else begin
                  tx_d = bus.datai;
               end
            end
         end

         ST_LEAD, ST_SHIFT: begin
            // The LEAD timeout produces edge 1; SHIFT produces edges 2..2W.
            if (tick) begin
               phase_d = ~phase_q;
               edge_d  = edge_q + 1'b1;
               state_d = last_edge ? ST_TRAIL : ST_SHIFT;
               if (leading) begin
                  if (!cpha_q) begin
                     rx_d = rx_next;
                  end else begin
                     din_d = tx_bit;
                     tx_d  = tx_rest;
                  end
               end else begin
                  if (cpha_q) begin
                     rx_d = rx_next;
                  end else if (!last_edge) begin
                     din_d = tx_bit;
                     tx_d  = tx_rest;
                  end
               end
            end
         end

         ST_TRAIL: begin
            if (tick) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               csb_d   = 1'b1;
               done_d  = 1'b1;
               datao_d = rx_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // While idle SCLK follows the live CPOL; during a transfer the latched one.
   assign bus.sclk  = phase_q ^ ((state_q == ST_IDLE) ? bus.CPOL : cpol_q);
   assign bus.datao = datao_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.csb   = csb_q;
   assign bus.din   = din_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with MISO looped back to MOSI.
module tb_spi_master;

  logic       clk;
  logic       resetb;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pats [4];

  spi_master_if #(.DATA_WIDTH(8), .CLK_DIVIDER_WIDTH(4)) bus ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIVIDER_WIDTH(4)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // loopback: slave echoes MOSI on MISO
  assign bus.dout = bus.din;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a request at a negedge, leave at the negedge of cycle t0+1
  task automatic start_xfer(input logic [7:0] d, input logic [1:0] mode, input logic [3:0] div);
    bus.datai       = d;
    bus.CPOL        = mode[1];
    bus.CPHA        = mode[0];
    bus.clk_divider = div;
    bus.go          = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  // scoreboard: wait for done (bounded), pop expected word, compare datao
  task automatic wait_done(input int budget, output int lat);
    logic [7:0] exp;
    lat = 1;
    while (bus.done !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    total++;
    assert (bus.done === 1'b1) else begin
      bad++;
      $error("FAIL done_timeout: observed done=%b expected done=1 within %0d cycles", bus.done, budget);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (bus.done === 1'b1) chk("datao", {24'd0, bus.datao}, {24'd0, exp});
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int edges;
    int edge_bad;
    int done_cyc;
    int done_cnt;
    logic prev_sclk;
    logic busy_at_done;
    logic csb_at_done;
    logic late_busy;
    logic [7:0] exp;

    pats[0] = 8'h00;
    pats[1] = 8'hA5;
    pats[2] = 8'h3C;
    pats[3] = 8'hFF;

    // reset with CPOL=1
    resetb          = 1'b0;
    bus.CPOL        = 1'b1;
    bus.CPHA        = 1'b0;
    bus.clk_divider = 4'd4;
    bus.go          = 1'b0;
    bus.datai       = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    chk("rst_csb",   {31'd0, bus.csb},   32'd1);
    chk("rst_din",   {31'd0, bus.din},   32'd0);
    chk("rst_datao", {24'd0, bus.datao}, 32'd0);
    chk("rst_sclk",  {31'd0, bus.sclk},  32'd1);

    // idle levels
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_sclk_cpol1", {31'd0, bus.sclk}, 32'd1);
    chk("idle_csb",        {31'd0, bus.csb},  32'd1);
    chk("idle_busy",       {31'd0, bus.busy}, 32'd0);
    bus.CPOL = 1'b0;
    #1;
    chk("idle_sclk_cpol0", {31'd0, bus.sclk}, 32'd0);
    @(negedge clk);

    // loopback in all four modes
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 4; p++) begin
        start_xfer(pats[p], 2'(m), 4'd4);
        wait_done(200, lat);
        @(negedge clk);
      end
    end

    // timing, mode 0, H=5
    start_xfer(8'hC3, 2'd0, 4'd4);
    chk("t_busy_t1", {31'd0, bus.busy}, 32'd1);
    chk("t_csb_t1",  {31'd0, bus.csb},  32'd0);
    chk("t_din_msb", {31'd0, bus.din},  32'd1);
    prev_sclk    = bus.sclk;
    edges        = 0;
    edge_bad     = 0;
    done_cyc     = 0;
    done_cnt     = 0;
    busy_at_done = 1'b1;
    csb_at_done  = 1'b0;
    late_busy    = 1'b1;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (done_cyc > 0 && c == done_cyc + 1) begin
        late_busy = bus.busy;
        bus.go    = 1'b0;
      end
      if (bus.sclk !== prev_sclk) begin
        edges++;
        if (c != 1 + edges * 5) edge_bad++;
        prev_sclk = bus.sclk;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc     = c;
          busy_at_done = bus.busy;
          csb_at_done  = bus.csb;
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk("t_datao", {24'd0, bus.datao}, {24'd0, exp});
          end
          // request in the done cycle must be dropped
          bus.datai = 8'h11;
          bus.go    = 1'b1;
        end
      end
    end
    bus.go = 1'b0;
    chk("t_edges",        32'(edges),          32'd16);
    chk("t_edge_spacing", 32'(edge_bad),       32'd0);
    chk("t_done_cycle",   32'(done_cyc),       32'd86);
    chk("t_done_pulses",  32'(done_cnt),       32'd1);
    chk("t_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    chk("t_csb_at_done",  {31'd0, csb_at_done},  32'd1);
    chk("t_go_in_done",   {31'd0, late_busy},    32'd0);
    settle();

    // go mid-transfer with different datai is ignored
    start_xfer(8'h96, 2'd1, 4'd2);
    repeat (20) @(negedge clk);
    bus.datai = 8'h69;
    bus.go    = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    wait_done(200, lat);
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("mid_extra_done", 32'(done_cnt), 32'd0);
    chk("mid_idle_busy",  {31'd0, bus.busy}, 32'd0);

    // reset during SHIFT
    start_xfer(8'h5A, 2'd2, 4'd4);
    repeat (30) @(negedge clk);
    chk("rs_in_shift", {30'd0, state_dbg}, 32'd2);
    resetb = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("rs_csb",   {31'd0, bus.csb},   32'd1);
    chk("rs_busy",  {31'd0, bus.busy},  32'd0);
    chk("rs_sclk",  {31'd0, bus.sclk},  32'd1);
    chk("rs_datao", {24'd0, bus.datao}, 32'd0);
    chk("rs_done",  {31'd0, bus.done},  32'd0);
    resetb = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("rs_no_done", 32'(done_cnt), 32'd0);
    start_xfer(8'hA5, 2'd2, 4'd4);
    wait_done(200, lat);
    chk("rs_after_lat", 32'(lat), 32'd86);
    @(negedge clk);

    // fastest clock, mode 3
    start_xfer(8'h3C, 2'd3, 4'd0);
    wait_done(60, lat);
    chk("fast_lat", 32'(lat), 32'd18);
    @(negedge clk);
    chk("fast_done_width", {31'd0, bus.done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-channel SPI bus master that performs one full-duplex transfer of DATA_WIDTH bits per `go` request.
- Supports all four SPI modes (CPOL/CPHA) and a programmable SCLK rate derived from the system clock.
- Sits between a host-side register/control interface and an external SPI slave; drives SCLK, chip select and MOSI, and samples MISO.

Parameters:
- DATA_WIDTH, 8, bits per transfer (shift register width).
- CLK_DIVIDER_WIDTH, 4, width of the clk_divider input.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetb  input  1  synchronous active-low reset.
- CPOL  input  1  SCLK idle level.
- CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
- clk_divider  input  CLK_DIVIDER_WIDTH  SCLK half-period control.
- go  input  1  transfer request, sampled high on a rising edge of clk.
- datai  input  DATA_WIDTH  transmit word, latched when go is accepted.
- datao  output  DATA_WIDTH  last received word.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse at transfer completion.
- sclk  output  1  SPI serial clock.
- csb  output  1  active-low chip select.
- din  output  1  serial data to the slave (MOSI).
- dout  input  1  serial data from the slave (MISO).

Behaviour:
- Reset (resetb=0 at a clk edge):
  - busy=0, done=0, csb=1, din=0, datao=0.
  - Internal SCLK phase cleared, so sclk=CPOL.
  - Reset aborts any transfer in progress immediately; no done pulse is produced.
- Clocking:
  - Half-period H = clk_divider+1 clk cycles; clk_divider=0 gives H=1.
  - clk_divider, CPOL, CPHA and datai are latched when go is accepted; later changes are ignored until the next transfer.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
- IDLE:
  - csb=1, busy=0, sclk=CPOL.
  - go=1 at cycle t0 is accepted; at t0+1: busy=1, csb=0, state=LEAD.
  - For CPHA=0, din presents the MSB at t0+1.
- LEAD: waits H cycles, then enters SHIFT.
- SHIFT: 2*DATA_WIDTH SCLK edges, edge k (k=1..16 for width 8) at cycle t0+1+k*H.
  - Odd k is a leading edge (sclk goes to !CPOL); even k is a trailing edge (sclk returns to CPOL).
  - CPHA=0: sample dout into the receive shift register LSB on leading edges; shift the next bit onto din on trailing edges (except the final one).
  - CPHA=1: drive the next bit onto din on leading edges; sample dout on trailing edges.
  - Bit order is MSB first.
- TRAIL:
  - Waits H cycles after the last edge, with sclk=CPOL.
  - At cycle t0+1+(2*DATA_WIDTH+1)*H: csb=1, busy=0, done=1 for exactly one cycle, and datao is loaded with the received word.
  - State returns to IDLE.
- Timing example: width 8, clk_divider=4 gives done at t0+86.
- datao holds its value until the next completed transfer.
- go while busy=1 is ignored. go asserted in the same cycle that done pulses is also ignored; it must be re-asserted.
- In loopback (dout tied to din), datao equals the transmitted datai in all four modes.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: transmit and receive are LSB first; the first transmitted bit is datai[0], and the first received bit lands in datao[0].
- Undefined: MSB first as specified above.
- Loopback results are identical either way.

Test Plan:
- Loopback (dout=din), clk_divider=4, each mode 0-3, patterns 00, A5, 3C, FF -> datao equals the sent value after each done; 16 passes.
- Idle levels: CPOL=1, no go -> sclk=1, csb=1, busy=0; then CPOL=0 -> sclk=0.
- Timing: go at t0, clk_divider=4 -> busy high at t0+1; 16 sclk edges spaced 5 cycles apart; done pulse exactly 1 cycle at t0+86; busy low the same cycle.
- go pulsed mid-transfer with a different datai -> ignored; datao equals the original word; exactly one done pulse.
- resetb low during SHIFT -> next cycle csb=1, busy=0, sclk=CPOL, datao=0, no done; a following transfer of A5 succeeds.
- clk_divider=0, mode 3, pattern 3C -> edges every cycle; done at t0+18; datao=3C.
